// File: rtl/mfp_ahb_lite_master_if.sv
// Command/response stream and AHB-Lite bus signals of the single-transfer AHB-Lite initiator.
// The master modport is the initiator's view; the slave modport is the command source plus bus slave side.
interface mfp_ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands in, NONSEQ/SINGLE transfers out, one response each.
// Define MFP_AHB_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  mfp_ahb_lite_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        vld_p0;
  logic [31:0] addr_p0;
  logic        write_p0;
  logic [2:0]  size_p0;
  logic [31:0] wdata_p0;

  logic        vld_p1;
  logic        write_p1;
  logic [31:0] wdata_p1;

  logic        vld_p2;
  logic        err_p2;
  logic [31:0] rdata_p2;

  logic err_hold;
  logic nonseq;
  logic advance;
  logic dp_done;
  logic cmd_fire;

  // An ERROR in the data phase holds the pending address phase off the bus for both error cycles.
  assign err_hold = vld_p1 && bus.HRESP;
  assign nonseq   = vld_p0 && !err_hold;
  assign advance  = nonseq && bus.HREADY;
  assign dp_done  = vld_p1 && bus.HREADY;

`ifdef MFP_AHB_MASTER_PIPELINE_EN
  assign bus.cmd_ready = !HRESET && (!vld_p0 || advance);
`else
  assign bus.cmd_ready = !HRESET && !vld_p0 && !vld_p1;
`endif

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      rdata_p2 <= '0;
    end else begin
      if (cmd_fire) begin
        vld_p0 <= 1'b1;
      end else if (advance) begin
        vld_p0 <= 1'b0;
      end

      if (advance) begin
        vld_p1 <= 1'b1;
      end else if (dp_done) begin
        vld_p1 <= 1'b0;
      end

      vld_p2 <= dp_done;
      if (dp_done) begin
        err_p2 <= bus.HRESP;
        if (!write_p1) begin
          rdata_p2 <= bus.HRDATA;
        end
      end
    end
  end

  // p0: address-phase slot, loaded on command acceptance
  always_ff @(posedge HCLK) begin
    if (cmd_fire) begin
      addr_p0  <= bus.cmd_addr;
      write_p0 <= bus.cmd_write;
      size_p0  <= bus.cmd_size;
      wdata_p0 <= bus.cmd_wdata;
    end
  end

  // p1: data-phase slot, loaded when the address phase is accepted by the slave
  always_ff @(posedge HCLK) begin
    if (advance) begin
      write_p1 <= write_p0;
      wdata_p1 <= wdata_p0;
    end
  end

  // p2: response, one cycle after the data phase completes
  assign bus.rsp_valid = vld_p2;
  assign bus.rsp_err   = err_p2;
  assign bus.rsp_rdata = rdata_p2;

  assign bus.HTRANS    = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = vld_p0 ? addr_p0  : '0;
  assign bus.HWRITE    = vld_p0 ? write_p0 : 1'b0;
  assign bus.HSIZE     = vld_p0 ? size_p0  : '0;
  assign bus.HWDATA    = vld_p1 ? wdata_p1 : '0;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VALUE;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master: vector table of isolated transfers plus
// back-to-back, ERROR-with-pending and reset-mid-wait sequences against a small AHB-Lite slave.
module tb_mfp_ahb_lite_master;

`ifdef MFP_AHB_MASTER_PIPELINE_EN
  localparam int         GAP     = 1;
  localparam logic [1:0] BETWEEN = 2'b10;
  localparam int         RI_OFF  = 4;
`else
  localparam int         GAP     = 3;
  localparam logic [1:0] BETWEEN = 2'b00;
  localparam int         RI_OFF  = 5;
`endif

  logic HCLK;
  logic HRESET;

  mfp_ahb_lite_master_if bus();

  mfp_ahb_lite_master #(.HPROT_VALUE(4'b0011)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] hi(input int x);
    return 10'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus history indexed by the cycle number after the edge (cycle E+1 follows edge E).
  logic [1:0]  htrans_h [1024];
  logic [31:0] haddr_h  [1024];
  logic [31:0] hwdata_h [1024];
  logic        hwrite_h [1024];
  logic [2:0]  hsize_h  [1024];
  logic        rdy_h    [1024];
  int          rsp_n = 0;
  int          rsp_idx [64];
  logic [31:0] rsp_dat [64];
  logic        rsp_e   [64];

  initial begin
    forever begin
      @(negedge HCLK);
      htrans_h[hi(cyc + 1)] = bus.HTRANS;
      haddr_h[hi(cyc + 1)]  = bus.HADDR;
      hwdata_h[hi(cyc + 1)] = bus.HWDATA;
      hwrite_h[hi(cyc + 1)] = bus.HWRITE;
      hsize_h[hi(cyc + 1)]  = bus.HSIZE;
      rdy_h[hi(cyc + 1)]    = bus.cmd_ready;
      if (bus.rsp_valid && rsp_n < 64) begin
        rsp_idx[6'(rsp_n)] = cyc + 1;
        rsp_dat[6'(rsp_n)] = bus.rsp_rdata;
        rsp_e[6'(rsp_n)]   = bus.rsp_err;
        rsp_n++;
      end
    end
  end

  // Word memory slave with configurable wait states and a two-cycle ERROR on one address.
  int          waits_cfg;
  logic        err_en;
  logic [31:0] err_addr;
  logic [31:0] mem [64];

  initial begin
    logic        s_act, s_write, s_err, s_estage;
    logic [31:0] s_addr;
    int          s_wait;
    logic        c_rst, c_ap, c_done, c_ap_write, c_resp;
    logic [31:0] c_ap_addr, c_wdata;
    for (int i = 0; i < 64; i++) mem[6'(i)] = 32'hC0DE_0000 | 32'(i * 4);
    mem[4] = 32'hDEAD_BEEF;
    s_act = 1'b0; s_write = 1'b0; s_err = 1'b0; s_estage = 1'b0; s_addr = '0; s_wait = 0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      c_rst      = HRESET;
      c_ap       = (bus.HTRANS == 2'b10) && bus.HREADY;
      c_ap_addr  = bus.HADDR;
      c_ap_write = bus.HWRITE;
      c_done     = s_act && bus.HREADY;
      c_resp     = bus.HRESP;
      c_wdata    = bus.HWDATA;
      @(posedge HCLK);
      #1;
      if (c_rst) begin
        s_act = 1'b0;
      end else begin
        if (c_done) begin
          if (s_write && !c_resp) mem[s_addr[7:2]] = c_wdata;
          s_act = 1'b0;
        end
        if (c_ap) begin
          s_act    = 1'b1;
          s_addr   = c_ap_addr;
          s_write  = c_ap_write;
          s_wait   = waits_cfg;
          s_err    = err_en && (c_ap_addr == err_addr);
          s_estage = 1'b0;
        end
      end
      if (!s_act) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
      end else if (s_err) begin
        bus.HRESP  = 1'b1;
        bus.HREADY = s_estage;
        s_estage   = 1'b1;
      end else if (s_wait > 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0;
        s_wait--;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        bus.HRDATA = s_write ? 32'h0 : mem[s_addr[7:2]];
      end
    end
  end

  // Presents one command and returns the edge number at which it was accepted.
  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, output int e);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = sz;
    bus.cmd_wdata = d;
    @(negedge HCLK);
    while (!bus.cmd_ready && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    @(posedge HCLK);
    #1;
    e = cyc;
    bus.cmd_valid = 1'b0;
    chk("cmd_accept_in_time", 32'(n < 50), 32'h1);
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [7:0]  waits;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_lat;
  } vec_t;

  vec_t vt [8];

  initial begin
    int   e, e0, e1, n0;
    int   ew [8];
    vec_t v;

    vt[0] = '{1'b0, 32'h10, 3'd2, 32'h0,         8'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd3};
    vt[1] = '{1'b1, 32'h20, 3'd2, 32'h1234_5678, 8'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 8'd5};
    vt[2] = '{1'b0, 32'h20, 3'd2, 32'h0,         8'd0, 1'b0, 32'h1234_5678, 1'b0, 8'd3};
    vt[3] = '{1'b0, 32'h24, 3'd1, 32'h0,         8'd1, 1'b0, 32'hC0DE_0024, 1'b0, 8'd4};
    vt[4] = '{1'b1, 32'h30, 3'd2, 32'hA5A5_0F0F, 8'd0, 1'b1, 32'hC0DE_0024, 1'b1, 8'd4};
    vt[5] = '{1'b0, 32'h30, 3'd0, 32'h0,         8'd0, 1'b0, 32'hC0DE_0030, 1'b0, 8'd3};
    vt[6] = '{1'b1, 32'h52, 3'd1, 32'h0000_BEEF, 8'd3, 1'b0, 32'hC0DE_0030, 1'b0, 8'd6};
    vt[7] = '{1'b0, 32'h50, 3'd2, 32'h0,         8'd0, 1'b0, 32'h0000_BEEF, 1'b0, 8'd3};

    waits_cfg = 0; err_en = 1'b0; err_addr = '0;
    HRESET = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'hFFFF_FFFC;
    bus.cmd_size = 3'd2; bus.cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    chk("reset_htrans",    32'(bus.HTRANS),    32'h0);
    chk("reset_haddr",     bus.HADDR,          32'h0);
    chk("reset_hwrite",    32'(bus.HWRITE),    32'h0);
    chk("reset_hsize",     32'(bus.HSIZE),     32'h0);
    chk("reset_hwdata",    bus.HWDATA,         32'h0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_err",   32'(bus.rsp_err),   32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata,      32'h0);
    chk("hburst",          32'(bus.HBURST),    32'h0);
    chk("hprot",           32'(bus.HPROT),     32'h3);
    chk("hmastlock",       32'(bus.HMASTLOCK), 32'h0);
    HRESET = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge HCLK);
    #1;
    chk("post_reset_htrans", 32'(bus.HTRANS),    32'h0);
    chk("post_reset_ready",  32'(bus.cmd_ready), 32'h1);

    for (int i = 0; i < 8; i++) begin
      v = vt[3'(i)];
      waits_cfg = int'(v.waits); err_en = v.err; err_addr = v.addr;
      n0 = rsp_n;
      issue(v.w, v.addr, v.size, v.wdata, e);
      repeat (12) @(posedge HCLK);
      #1;
      chk($sformatf("v%0d_htrans_ap", i), 32'(htrans_h[hi(e + 1)]), 32'h2);
      chk($sformatf("v%0d_haddr", i),     haddr_h[hi(e + 1)],       v.addr);
      chk($sformatf("v%0d_hwrite", i),    32'(hwrite_h[hi(e + 1)]), 32'(v.w));
      chk($sformatf("v%0d_hsize", i),     32'(hsize_h[hi(e + 1)]),  32'(v.size));
      chk($sformatf("v%0d_hwdata_ap", i), hwdata_h[hi(e + 1)],      32'h0);
      for (int k = 2; k < int'(v.exp_lat); k++)
        chk($sformatf("v%0d_hwdata_dp%0d", i, k), hwdata_h[hi(e + k)], v.wdata);
      chk($sformatf("v%0d_rsp_count", i), 32'(rsp_n), 32'(n0 + 1));
      if (rsp_n > n0) begin
        chk($sformatf("v%0d_latency", i), 32'(rsp_idx[6'(n0)] - e), 32'(v.exp_lat));
        chk($sformatf("v%0d_rdata", i),   rsp_dat[6'(n0)],           v.exp_rdata);
        chk($sformatf("v%0d_err", i),     32'(rsp_e[6'(n0)]),        32'(v.exp_err));
      end
    end

    // Four writes then four reads, presented back to back.
    waits_cfg = 0; err_en = 1'b0;
    n0 = rsp_n;
    for (int k = 0; k < 4; k++) issue(1'b1, 32'(k * 4), 3'd2, 32'(32'h1111_1111 * (k + 1)), ew[3'(k)]);
    for (int k = 0; k < 4; k++) issue(1'b0, 32'(k * 4), 3'd2, 32'h0, ew[3'(4 + k)]);
    repeat (16) @(posedge HCLK);
    #1;
    for (int k = 1; k < 8; k++)
      chk($sformatf("b2b_gap%0d", k), 32'(ew[3'(k)] - ew[3'(k - 1)]), 32'(GAP));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_nonseq%0d", k),  32'(htrans_h[hi(ew[3'(k)] + 1)]), 32'h2);
      chk($sformatf("b2b_between%0d", k), 32'(htrans_h[hi(ew[3'(k)] + 2)]), 32'(BETWEEN));
    end
    chk("b2b_rsp_count", 32'(rsp_n), 32'(n0 + 8));
    for (int k = 0; k < 4; k++)
      chk($sformatf("b2b_rdata%0d", k), rsp_dat[6'(n0 + 4 + k)], 32'(32'h1111_1111 * (k + 1)));
    for (int k = 0; k < 8; k++)
      chk($sformatf("b2b_err%0d", k), 32'(rsp_e[6'(n0 + k)]), 32'h0);

    // ERROR on a write while a read waits for the address phase.
    waits_cfg = 0; err_en = 1'b1; err_addr = 32'h40;
    n0 = rsp_n;
    issue(1'b1, 32'h40, 3'd2, 32'hE0E0_E0E0, e0);
    issue(1'b0, 32'h44, 3'd2, 32'h0, e1);
    repeat (12) @(posedge HCLK);
    #1;
    chk("err_hold_cycle1",  32'(htrans_h[hi(e0 + 2)]), 32'h0);
    chk("err_hold_cycle2",  32'(htrans_h[hi(e0 + 3)]), 32'h0);
    chk("err_reissue",      32'(htrans_h[hi(e0 + RI_OFF)]), 32'h2);
    chk("err_reissue_addr", haddr_h[hi(e0 + RI_OFF)], 32'h44);
    chk("err_rsp_count",    32'(rsp_n), 32'(n0 + 2));
    if (rsp_n >= n0 + 2) begin
      chk("err_write_rsp_cycle", 32'(rsp_idx[6'(n0)] - e0), 32'h4);
      chk("err_write_rsp_err",   32'(rsp_e[6'(n0)]), 32'h1);
      chk("err_read_rsp_cycle",  32'(rsp_idx[6'(n0 + 1)] - e0), 32'(RI_OFF + 2));
      chk("err_read_rsp_err",    32'(rsp_e[6'(n0 + 1)]), 32'h0);
      chk("err_read_rdata",      rsp_dat[6'(n0 + 1)], 32'hC0DE_0044);
    end

    // Reset pulse in the first wait cycle of a write's data phase.
    waits_cfg = 3; err_en = 1'b0;
    n0 = rsp_n;
    issue(1'b1, 32'h60, 3'd2, 32'h600D_600D, e);
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    waits_cfg = 0;
    repeat (10) @(posedge HCLK);
    #1;
    chk("rst_mid_dp_hwdata", hwdata_h[hi(e + 2)], 32'h600D_600D);
    chk("rst_mid_cmd_ready", 32'(rdy_h[hi(e + 2)]), 32'h0);
    chk("rst_mid_htrans",    32'(htrans_h[hi(e + 3)]), 32'h0);
    chk("rst_mid_hwdata",    hwdata_h[hi(e + 3)], 32'h0);
    chk("rst_mid_no_rsp",    32'(rsp_n), 32'(n0));
    chk("rst_mid_rsp_rdata", bus.rsp_rdata, 32'h0);
    issue(1'b0, 32'h60, 3'd2, 32'h0, e);
    repeat (8) @(posedge HCLK);
    #1;
    chk("rst_after_htrans",  32'(htrans_h[hi(e + 1)]), 32'h2);
    chk("rst_after_count",   32'(rsp_n), 32'(n0 + 1));
    if (rsp_n > n0) begin
      chk("rst_after_latency", 32'(rsp_idx[6'(n0)] - e), 32'h3);
      chk("rst_after_rdata",   rsp_dat[6'(n0)], 32'hC0DE_0060);
      chk("rst_after_err",     32'(rsp_e[6'(n0)]), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
